// File: rtl/line_fill_responder_pkg.sv
// Shared types and constants for the line fill responder.
// Imported by the interface, the RAM and the top.
package line_fill_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST
  } state_t;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_LATENCY    = 4;

  localparam int WORD_W = 32;
  localparam int OFF_W  = $clog2(DEF_LINE_WORDS);
  localparam int LAT_W  = 4;

endpackage

// File: rtl/line_fill_responder_if.sv
// Request, preload and beat signals of the fill responder.
// master drives requests/preloads, slave returns beats.
interface line_fill_responder_if
  import line_fill_responder_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS
) ();

  localparam int OW = $clog2(LINE_WORDS);

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_data;
  logic [OW-1:0]     rsp_word;
  logic              rsp_last;
  logic              busy;

  modport master (
    output req_valid, req_addr,
    output wr_en, wr_addr, wr_data,
    input  req_ready, busy,
    input  rsp_valid, rsp_data,
    input  rsp_word, rsp_last
  );

  modport slave (
    input  req_valid, req_addr,
    input  wr_en, wr_addr, wr_data,
    output req_ready, busy,
    output rsp_valid, rsp_data,
    output rsp_word, rsp_last
  );

endinterface

// File: rtl/line_fill_responder_fill_ram.sv
// Word-addressed backing store, one write and one read port.
// A same-cycle read of the written word returns the old value.
module fill_ram
  import line_fill_responder_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WORD_W-1:0]        rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read, holds when not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/line_fill_responder.sv
// Critical-word-first line fill responder for an I-cache.
// WAIT counts latency, BURST streams one beat per cycle.
module line_fill_responder
  import line_fill_responder_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = DEF_LATENCY,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input logic                  clk,
  input logic                  rst_n,
  line_fill_responder_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int TW = 30 - OW;

  localparam logic [LAT_W-1:0] LAT_END =
    LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [OW-1:0] BEAT_END =
    OW'(LINE_WORDS - 1);

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [OW-1:0]     beat_q, beat_d;
  logic [TW-1:0]     tag_q;
  logic [OW-1:0]     start_q;
  logic [OW-1:0]     word_q;
  logic              valid_q, last_q;

  logic              accept;
  logic              issue;
  logic [OW-1:0]     issue_n;
  logic [TW-1:0]     rd_tag;
  logic [OW-1:0]     rd_start;
  logic [OW-1:0]     rd_word;
  logic [29:0]       rd_full;
  logic [WORD_W-1:0] rd_data;

  assign accept  = bus.req_valid && (state_q == IDLE);
  assign rd_word = rd_start + issue_n;
  assign rd_full = {rd_tag, rd_word};

  // Next state, counters and the beat read to issue this cycle.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    issue    = 1'b0;
    issue_n  = '0;
    rd_tag   = tag_q;
    rd_start = start_q;
    unique case (1'b1)
      state_q == IDLE: begin
        if (bus.req_valid) begin
          lat_d  = '0;
          beat_d = '0;
          if (LATENCY == 0) begin
            state_d  = BURST;
            issue    = 1'b1;
            rd_tag   = bus.req_addr[31:OW+2];
            rd_start = bus.req_addr[OW+1:2];
          end else begin
            state_d = WAIT;
          end
        end
      end
      state_q == WAIT: begin
        lat_d = lat_q + LAT_W'(1);
        if (lat_q == LAT_END) begin
          state_d = BURST;
          issue   = 1'b1;
        end
      end
      state_q == BURST: begin
        if (beat_q == BEAT_END) begin
          state_d = IDLE;
        end else begin
          issue   = 1'b1;
          issue_n = beat_q + OW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) beat_d = issue_n;
  end

  // FSM, counters and captured line tag / start word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      tag_q   <= '0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      if (accept) begin
        tag_q   <= bus.req_addr[31:OW+2];
        start_q <= bus.req_addr[OW+1:2];
      end
    end
  end

  // Beat flags and index, registered alongside the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      valid_q <= issue;
      last_q  <= issue && (issue_n == BEAT_END);
      if (issue) word_q <= rd_word;
    end
  end

  fill_ram #(
    .DEPTH (MEM_WORDS)
  ) u_fill_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr[AW+1:2]),
    .wr_data (bus.wr_data),
    .rd_en   (issue),
    .rd_addr (rd_full[AW-1:0]),
    .rd_data (rd_data)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_last  = last_q;
  assign bus.rsp_word  = word_q;
  assign bus.rsp_data  = rd_data;

  logic unused_bits;
  assign unused_bits = ^{bus.req_addr[1:0],
                         bus.wr_addr[31:AW+2],
                         bus.wr_addr[1:0],
                         rd_full[29:AW]};

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench: two responders (latency 4 and 0)
// share one stimulus stream and are checked side by side.
module tb_line_fill_responder;
  import line_fill_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int vectors     = 0;
  int miscompares = 0;

  int lat_of [2] = '{4, 0};

  logic        s_valid [2];
  logic        s_last  [2];
  logic        s_ready [2];
  logic        s_busy  [2];
  logic [31:0] s_data  [2];
  logic [1:0]  s_word  [2];

  logic [1:0]  w [4];
  logic [31:0] d [4];

  always #5 clk = ~clk;

  line_fill_responder_if #(.LINE_WORDS(4)) bus4 ();
  line_fill_responder_if #(.LINE_WORDS(4)) bus0 ();

  assign bus4.req_valid = req_valid;
  assign bus4.req_addr  = req_addr;
  assign bus4.wr_en     = wr_en;
  assign bus4.wr_addr   = wr_addr;
  assign bus4.wr_data   = wr_data;
  assign bus0.req_valid = req_valid;
  assign bus0.req_addr  = req_addr;
  assign bus0.wr_en     = wr_en;
  assign bus0.wr_addr   = wr_addr;
  assign bus0.wr_data   = wr_data;

  line_fill_responder #(
    .MEM_WORDS  (1024),
    .LATENCY    (4),
    .LINE_WORDS (4)
  ) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  line_fill_responder #(
    .MEM_WORDS  (1024),
    .LATENCY    (0),
    .LINE_WORDS (4)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    s_valid[0] = bus4.rsp_valid;
    s_last[0]  = bus4.rsp_last;
    s_ready[0] = bus4.req_ready;
    s_busy[0]  = bus4.busy;
    s_data[0]  = bus4.rsp_data;
    s_word[0]  = bus4.rsp_word;
    s_valid[1] = bus0.rsp_valid;
    s_last[1]  = bus0.rsp_last;
    s_ready[1] = bus0.req_ready;
    s_busy[1]  = bus0.busy;
    s_data[1]  = bus0.rsp_data;
    s_word[1]  = bus0.rsp_word;
  endtask

  task automatic write_word(input logic [31:0] a,
                            input logic [31:0] v);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = v;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic run_fill(input string       name,
                          input logic [31:0] addr,
                          input logic [1:0]  ew [4],
                          input logic [31:0] ed [4]);
    req_addr  = addr;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        int   n;
        logic ev, el;
        n  = c - lat_of[k] - 1;
        ev = (n >= 0) && (n < 4);
        el = (n == 3);
        vectors++;
        if ({s_valid[k], s_last[k]} !== {ev, el}) begin
          miscompares++;
          $display("FAIL %s lat%0d c%0d valid,last got %b%b exp %b%b",
                   name, lat_of[k], c, s_valid[k], s_last[k], ev, el);
        end
        if (ev) begin
          vectors++;
          if ({s_word[k], s_data[k]} !== {ew[n], ed[n]}) begin
            miscompares++;
            $display("FAIL %s lat%0d c%0d word,data got %0d %h exp %0d %h",
                     name, lat_of[k], c, s_word[k], s_data[k],
                     ew[n], ed[n]);
          end
          vectors++;
          if ({s_ready[k], s_busy[k]} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s lat%0d c%0d ready,busy got %b%b exp 01",
                     name, lat_of[k], c, s_ready[k], s_busy[k]);
          end
        end
        if (n == 4) begin
          vectors++;
          if ({s_ready[k], s_busy[k], s_word[k], s_data[k]} !==
              {2'b10, ew[3], ed[3]}) begin
            miscompares++;
            $display("FAIL %s lat%0d c%0d idle hold got %b%b %0d %h exp 10 %0d %h",
                     name, lat_of[k], c, s_ready[k], s_busy[k],
                     s_word[k], s_data[k], ew[3], ed[3]);
          end
        end
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    #12;
    sample();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({s_ready[k], s_busy[k], s_valid[k], s_last[k],
           s_word[k], s_data[k]} !== {4'b1000, 2'b00, 32'h0}) begin
        miscompares++;
        $display("FAIL reset lat%0d got r%b b%b v%b l%b w%0d d%h exp r1 b0 v0 l0 w0 d0",
                 lat_of[k], s_ready[k], s_busy[k], s_valid[k],
                 s_last[k], s_word[k], s_data[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_preload();
    for (int i = 0; i < 4; i++) begin
      write_word(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      write_word(32'(4 * i), 32'hD0 + 32'(i));
    end
  endtask

  task automatic test_aligned();
    w = '{2'd0, 2'd1, 2'd2, 2'd3};
    d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_fill("aligned_100", 32'h100, w, d);
  endtask

  task automatic test_wrap();
    w = '{2'd3, 2'd0, 2'd1, 2'd2};
    d = '{32'hA3, 32'hA0, 32'hA1, 32'hA2};
    run_fill("wrap_10c", 32'h10C, w, d);
  endtask

  task automatic test_addr_low();
    w = '{2'd1, 2'd2, 2'd3, 2'd0};
    d = '{32'hA1, 32'hA2, 32'hA3, 32'hA0};
    run_fill("low_107", 32'h107, w, d);
  endtask

  task automatic test_alias();
    w = '{2'd0, 2'd1, 2'd2, 2'd3};
    d = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
    run_fill("alias_1000", 32'h1000, w, d);
  endtask

  task automatic test_back_to_back();
    req_addr  = 32'h100;
    req_valid = 1'b1;
    step();
    for (int c = 1; c <= 22; c++) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        int   l, n;
        logic ev, el, er;
        l  = lat_of[k];
        ev = (c >= l + 1 && c <= l + 4) ||
             (c >= 2 * l + 6 && c <= 2 * l + 9);
        el = (c == l + 4) || (c == 2 * l + 9);
        er = (c == l + 5) || (c >= 2 * l + 10);
        n  = (c <= l + 4) ? c - l - 1 : c - 2 * l - 6;
        vectors++;
        if ({s_valid[k], s_last[k], s_ready[k]} !== {ev, el, er}) begin
          miscompares++;
          $display("FAIL b2b lat%0d c%0d valid,last,ready got %b%b%b exp %b%b%b",
                   l, c, s_valid[k], s_last[k], s_ready[k], ev, el, er);
        end
        if (ev) begin
          vectors++;
          if (s_data[k] !== 32'(32'hA0 + n)) begin
            miscompares++;
            $display("FAIL b2b lat%0d c%0d data got %h exp %h",
                     l, c, s_data[k], 32'(32'hA0 + n));
          end
        end
      end
      if (c == 10) req_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_abort();
    req_addr  = 32'h100;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (5) step();
    sample();
    vectors++;
    if ({s_valid[0], s_word[0], s_data[0]} !== {1'b1, 2'd1, 32'hA1}) begin
      miscompares++;
      $display("FAIL abort_pre beat1 got v%b w%0d d%h exp v1 w1 dA1",
               s_valid[0], s_word[0], s_data[0]);
    end
    rst_n = 1'b0;
    #1;
    sample();
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({s_valid[k], s_last[k], s_ready[k], s_busy[k],
           s_word[k], s_data[k]} !== {4'b0010, 2'b00, 32'h0}) begin
        miscompares++;
        $display("FAIL abort lat%0d got v%b l%b r%b b%b w%0d d%h exp v0 l0 r1 b0 w0 d0",
                 lat_of[k], s_valid[k], s_last[k], s_ready[k],
                 s_busy[k], s_word[k], s_data[k]);
      end
    end
    #2;
    rst_n = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if ({s_valid[k], s_ready[k]} !== 2'b01) begin
          miscompares++;
          $display("FAIL post_abort lat%0d c%0d valid,ready got %b%b exp 01",
                   lat_of[k], c, s_valid[k], s_ready[k]);
        end
      end
      step();
    end
    w = '{2'd0, 2'd1, 2'd2, 2'd3};
    d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_fill("mem_intact", 32'h100, w, d);
  endtask

  task automatic test_rbw();
    req_addr  = 32'h100;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      sample();
      if (c == 5) begin
        vectors++;
        if ({s_valid[0], s_word[0], s_data[0]} !== {1'b1, 2'd0, 32'hA0}) begin
          miscompares++;
          $display("FAIL rbw_old got v%b w%0d d%h exp v1 w0 dA0",
                   s_valid[0], s_word[0], s_data[0]);
        end
      end
      if (c == 4) begin
        wr_en   = 1'b1;
        wr_addr = 32'h100;
        wr_data = 32'hBEEF;
      end
      if (c == 5) wr_en = 1'b0;
      step();
    end
    w = '{2'd0, 2'd1, 2'd2, 2'd3};
    d = '{32'hBEEF, 32'hA1, 32'hA2, 32'hA3};
    run_fill("rbw_new", 32'h100, w, d);
  endtask

  initial begin
    test_reset();
    test_preload();
    test_aligned();
    test_wrap();
    test_addr_low();
    test_alias();
    test_back_to_back();
    test_reset_abort();
    test_rbw();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
